ahbl_master_arbiter: RTL

Two-master to one-slave-bus AHB-Lite arbiter/multiplexer for the AMBA BFM testbench environment. It lets two AHB-Lite masters share one AHB-Lite bus, for example a BFM master and a DMA/test master. Both masters are typically BFM_AHBL instances.
- Round-robin arbitration.
- Ownership changes only at safe transfer boundaries.
- Address and data phases are routed independently, so pipelining is preserved.

---
 rtl/ahbl_master_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin grant at safe IDLE boundaries, independent address/data phase routing.
// Optional build macro AHBL_ARB_FIXED_PRIO_EN gives master 0 fixed priority instead of round-robin.
module ahbl_master_arbiter #(
  parameter int DATA_W      = 32,
  parameter bit PARK_MASTER = 1'b0
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic [31:0]       M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic [3:0]        M0_HPROT,
  input  logic              M0_HMASTLOCK,
  input  logic [DATA_W-1:0] M0_HWDATA,
  input  logic [31:0]       M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic [3:0]        M1_HPROT,
  input  logic              M1_HMASTLOCK,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic              M0_HREADY,
  output logic              M0_HRESP,
  output logic              M1_HREADY,
  output logic              M1_HRESP,
  output logic [DATA_W-1:0] M_HRDATA,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              ADDR_OWNER,
  output logic              DP_OWNER,
  output logic              DP_VALID
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic addr_owner;
  logic dp_owner;
  logic dp_valid;
  logic rr_last;

  logic owner_idle;
  logic owner_lock;
  logic req0;
  logic req1;
  logic grant_valid;
  logic next_owner;
  logic switch_en;

  assign req0 = (M0_HTRANS == TRANS_NONSEQ) && (addr_owner == 1'b1);
  assign req1 = (M1_HTRANS == TRANS_NONSEQ) && (addr_owner == 1'b0);

  always_comb begin
    grant_valid = 1'b0;
    next_owner  = addr_owner;
`ifdef AHBL_ARB_FIXED_PRIO_EN
    if (req0) begin
      grant_valid = 1'b1;
      next_owner  = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      next_owner  = 1'b1;
    end
`else
    if (req0 && req1) begin
      grant_valid = 1'b1;
      next_owner  = ~rr_last;
    end else if (req0) begin
      grant_valid = 1'b1;
      next_owner  = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      next_owner  = 1'b1;
    end
`endif
  end

  // Ownership moves only between transfers: owner idle, unlocked, and the bus not stalled.
  assign owner_idle = addr_owner ? (M1_HTRANS == TRANS_IDLE) : (M0_HTRANS == TRANS_IDLE);
  assign owner_lock = addr_owner ? M1_HMASTLOCK : M0_HMASTLOCK;
  assign switch_en  = HREADY && owner_idle && !owner_lock && grant_valid;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      addr_owner <= PARK_MASTER;
      rr_last    <= PARK_MASTER;
    end else if (switch_en) begin
      addr_owner <= next_owner;
      rr_last    <= next_owner;
    end
  end

  // The data phase belongs to whoever owned the address phase at the completing edge.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      dp_valid <= 1'b0;
      dp_owner <= 1'b0;
    end else if (HREADY) begin
      dp_valid <= HTRANS[1];
      dp_owner <= addr_owner;
    end
  end

  always_comb begin
    HADDR     = M0_HADDR;
    HTRANS    = M0_HTRANS;
    HWRITE    = M0_HWRITE;
    HSIZE     = M0_HSIZE;
    HBURST    = M0_HBURST;
    HPROT     = M0_HPROT;
    HMASTLOCK = M0_HMASTLOCK;
    if (addr_owner) begin
      HADDR     = M1_HADDR;
      HTRANS    = M1_HTRANS;
      HWRITE    = M1_HWRITE;
      HSIZE     = M1_HSIZE;
      HBURST    = M1_HBURST;
      HPROT     = M1_HPROT;
      HMASTLOCK = M1_HMASTLOCK;
    end
  end

  always_comb begin
    if (dp_valid) HWDATA = dp_owner ? M1_HWDATA : M0_HWDATA;
    else          HWDATA = addr_owner ? M1_HWDATA : M0_HWDATA;
  end

  assign M0_HREADY = HREADY && ((addr_owner == 1'b0) || (dp_valid && (dp_owner == 1'b0)));
  assign M1_HREADY = HREADY && ((addr_owner == 1'b1) || (dp_valid && (dp_owner == 1'b1)));
  assign M0_HRESP  = HRESP && dp_valid && (dp_owner == 1'b0);
  assign M1_HRESP  = HRESP && dp_valid && (dp_owner == 1'b1);
  assign M_HRDATA  = HRDATA;

  assign ADDR_OWNER = addr_owner;
  assign DP_OWNER   = dp_owner;
  assign DP_VALID   = dp_valid;

endmodule
